// File: rtl/mxint8_quantize_if.sv
// Handshake and data bundle for the MXINT8 block quantizer.
// master: the producer/consumer side (drives i_*); slave: the quantizer itself.
interface mxint8_quantize_if #(
    parameter int BLOCK_SIZE = 32
);
    logic                      i_valid;
    logic [31:0]               i_float32;
    logic                      o_ready;
    logic                      o_valid;
    logic                      i_ready;
    logic [7:0]                o_scale;
    logic [BLOCK_SIZE*8-1:0]   o_mxint8_elements;
    logic                      o_nan;

    modport master (
        output i_valid, i_float32, i_ready,
        input  o_ready, o_valid, o_scale, o_mxint8_elements, o_nan
    );

    modport slave (
        input  i_valid, i_float32, i_ready,
        output o_ready, o_valid, o_scale, o_mxint8_elements, o_nan
    );
endinterface

// File: rtl/mxint8_quantize.sv
// MXINT8 block quantizer: collects BLOCK_SIZE float32 elements, finds the
// largest biased exponent as the shared E8M0 scale, then converts one element
// per cycle into INT8 with an implicit 2^-6 scale and holds the block until
// the consumer takes it.
// Optional feature: define MXINT8_QUANT_RNE_EN for round-to-nearest-even;
// otherwise the conversion truncates toward zero.
// Element i of the block appears on o_mxint8_elements[8*i+7 : 8*i].
module mxint8_quantize #(
    parameter int BLOCK_SIZE = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mxint8_quantize_if.slave    bus
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0] CONV_END = CNT_W'(BLOCK_SIZE);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       max_exp_q, max_exp_d;
    logic             nan_q, nan_d;

    logic             accept;
    logic [7:0]       in_exp;

    logic [31:0]      buf_mem [BLOCK_SIZE];
    logic [31:0]      rd_q;

    logic             conv_we;
    logic [CNT_W-1:0] conv_idx;
    logic [7:0]       conv_elem;

    assign accept = (state_q == ST_COLLECT) && bus.i_valid;
    assign in_exp = bus.i_float32[30:23];

    // Sequencing: in CONVERT, cnt walks 0..BLOCK_SIZE; step k reads buffer[k]
    // and writes element k-1, so the RAM read latency costs one extra cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_exp_d = max_exp_q;
        nan_d     = nan_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_exp > max_exp_q) begin
                        max_exp_d = in_exp;
                    end
                    if (in_exp == 8'hFF) begin
                        nan_d = 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                if (cnt_q == CONV_END) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.i_ready) begin
                    state_d   = ST_COLLECT;
                    max_exp_d = 8'd0;
                    nan_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers; reset discards any partial block.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            max_exp_q <= 8'd0;
            nan_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_exp_q <= max_exp_d;
            nan_q     <= nan_d;
        end
    end

    // Element buffer write port (block RAM, no reset needed).
    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_mem[cnt_q[IDX_W-1:0]] <= bus.i_float32;
        end
    end

    // Registered buffer read feeding the converter.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_CONVERT) begin
            rd_q <= buf_mem[cnt_q[IDX_W-1:0]];
        end
    end

    // Float32 to INT8 conversion of the element held in rd_q.
    logic [7:0]  rd_exp;
    logic [8:0]  shift;
    logic [31:0] m_ext;
    logic [31:0] mag_trunc;
    logic [31:0] mag_round;
    logic [7:0]  mag;
`ifdef MXINT8_QUANT_RNE_EN
    logic        guard_bit;
    logic        sticky_bit;
`endif

    always_comb begin
        rd_exp    = rd_q[30:23];
        m_ext     = {8'd0, 1'b1, rd_q[22:0]};
        shift     = 9'd17 + {1'b0, max_exp_q - rd_exp};
        mag_trunc = 32'd0;
`ifdef MXINT8_QUANT_RNE_EN
        guard_bit  = 1'b0;
        sticky_bit = 1'b0;
`endif
        // Shifts of 31+ contribute nothing (and no rounding bits either).
        if (shift < 9'd31) begin
            mag_trunc = m_ext >> shift[4:0];
`ifdef MXINT8_QUANT_RNE_EN
            guard_bit  = m_ext[shift[4:0] - 5'd1];
            sticky_bit = |(m_ext & ((32'd1 << (shift[4:0] - 5'd1)) - 32'd1));
`endif
        end
`ifdef MXINT8_QUANT_RNE_EN
        mag_round = mag_trunc + {31'd0, guard_bit & (sticky_bit | mag_trunc[0])};
`else
        mag_round = mag_trunc;
`endif
        // A round-up to 128 saturates at the largest INT8 magnitude.
        mag = (mag_round > 32'd127) ? 8'd127 : mag_round[7:0];
        if (nan_q || (rd_exp == 8'd0)) begin
            conv_elem = 8'd0;
        end else if (rd_q[31]) begin
            conv_elem = ~mag + 8'd1;
        end else begin
            conv_elem = mag;
        end
    end

    assign conv_we  = (state_q == ST_CONVERT) && (cnt_q != '0);
    assign conv_idx = cnt_q - CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
            logic [7:0] elem_q, elem_d;

            // Capture the converted value when this element's turn comes.
            always_comb begin
                elem_d = elem_q;
                if (conv_we && (conv_idx == CNT_W'(gi))) begin
                    elem_d = conv_elem;
                end
            end

            // Output element register, cleared by reset.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    elem_q <= 8'd0;
                end else begin
                    elem_q <= elem_d;
                end
            end

            assign bus.o_mxint8_elements[gi*8 +: 8] = elem_q;
        end
    endgenerate

    assign bus.o_ready = (state_q == ST_COLLECT);
    assign bus.o_valid = (state_q == ST_HOLD);
    assign bus.o_scale = max_exp_q;
    assign bus.o_nan   = nan_q;
endmodule

// File: tb/tb_mxint8_quantize.sv
// Self-checking bench for mxint8_quantize: directed vectors plus randomized
// blocks checked against a real-arithmetic reference model.
module tb_mxint8_quantize;
    localparam int BS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mxint8_quantize_if #(.BLOCK_SIZE(BS)) bus();

    mxint8_quantize #(.BLOCK_SIZE(BS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] blk      [BS];
    logic [7:0]  exp_elem [BS];
    logic [7:0]  exp_scale;
    logic        exp_nan;

    // Quantize one float: value / 2^(max_e-127) * 64, rounded, saturated.
    function automatic logic [7:0] quant_one(input logic [31:0] f, input logic [7:0] max_e);
        real x;
        int  k;
        int  mag;
`ifdef MXINT8_QUANT_RNE_EN
        real fr;
`endif
        if (f[30:23] == 8'd0) return 8'd0;
        x = 1.0 + real'(f[22:0]) / 8388608.0;
        k = int'(f[30:23]) - int'(max_e) + 6;
        if (k > 0) begin
            for (int j = 0; j < k; j++) x = x * 2.0;
        end else begin
            for (int j = 0; j < -k; j++) x = x * 0.5;
        end
        mag = $rtoi(x);
`ifdef MXINT8_QUANT_RNE_EN
        fr = x - real'(mag);
        if (fr > 0.5 || (fr == 0.5 && (mag % 2) == 1)) mag = mag + 1;
`endif
        if (mag > 127) mag = 127;
        if (f[31]) mag = -mag;
        return 8'(mag);
    endfunction

    function automatic void model();
        logic [7:0] max_e;
        max_e   = 8'd0;
        exp_nan = 1'b0;
        for (int i = 0; i < BS; i++) begin
            if (blk[i][30:23] > max_e) max_e = blk[i][30:23];
            if (blk[i][30:23] == 8'hFF) exp_nan = 1'b1;
        end
        exp_scale = exp_nan ? 8'hFF : max_e;
        for (int i = 0; i < BS; i++) begin
            exp_elem[i] = exp_nan ? 8'd0 : quant_one(blk[i], max_e);
        end
    endfunction

    function automatic logic [31:0] rand_elem(input int base);
        int r;
        logic [7:0] e;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 32'd0;
        if (r == 1) return {1'($urandom), 8'd0, 23'($urandom)};
        e = 8'(base - int'($urandom_range(0, (r > 12) ? 40 : 10)));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic send_block(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.i_valid = 1'b0;
                @(negedge clk);
            end
            checks++;
            if (bus.o_ready !== 1'b1) begin
                errors++;
                $display("FAIL accept_ready elem %0d: got %b expected 1", i, bus.o_ready);
            end
            bus.i_valid   = 1'b1;
            bus.i_float32 = blk[i];
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_result();
        int edges = 0;
        bit ready_seen = 0;
        while (bus.o_valid !== 1'b1 && edges < 200) begin
            if (bus.o_ready !== 1'b0) ready_seen = 1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checks++;
        if (edges != BS + 1) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d", edges, BS + 1);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL ready_in_convert: got 1 expected 0");
        end
    endtask

    task automatic check_block(input string name);
        checks++;
        if (bus.o_scale !== exp_scale) begin
            errors++;
            $display("FAIL %s scale: got %h expected %h", name, bus.o_scale, exp_scale);
        end
        checks++;
        if (bus.o_nan !== exp_nan) begin
            errors++;
            $display("FAIL %s nan: got %b expected %b", name, bus.o_nan, exp_nan);
        end
        for (int i = 0; i < BS; i++) begin
            checks++;
            if (bus.o_mxint8_elements[i*8 +: 8] !== exp_elem[i]) begin
                errors++;
                $display("FAIL %s elem %0d (in %h): got %h expected %h",
                         name, i, blk[i], bus.o_mxint8_elements[i*8 +: 8], exp_elem[i]);
            end
        end
    endtask

    task automatic release_block(input string name);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%b ready=%b expected valid=0 ready=1",
                     name, bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic run_block(input string name, input bit gaps, input bit use_model);
        if (use_model) model();
        send_block(BS, gaps);
        wait_result();
        check_block(name);
        $display("block %s: scale=%h nan=%b e0=%h e1=%h", name, bus.o_scale, bus.o_nan,
                 bus.o_mxint8_elements[7:0], bus.o_mxint8_elements[15:8]);
        release_block(name);
    endtask

    task automatic clear_expect();
        for (int i = 0; i < BS; i++) begin
            blk[i]      = 32'd0;
            exp_elem[i] = 8'd0;
        end
        exp_scale = 8'd0;
        exp_nan   = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_float32 = 32'd0;
        bus.i_ready   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_scale !== 8'h00 ||
            bus.o_nan !== 1'b0 || bus.o_mxint8_elements !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b scale=%h nan=%b expected 1 0 00 0",
                     bus.o_ready, bus.o_valid, bus.o_scale, bus.o_nan);
        end
        rst = 1'b0;
        $display("reset: ready=%b valid=%b scale=%h", bus.o_ready, bus.o_valid, bus.o_scale);
    endtask

    task automatic test_ones();
        clear_expect();
        for (int i = 0; i < BS; i++) begin
            blk[i]      = 32'h3F800000;
            exp_elem[i] = 8'h40;
        end
        exp_scale = 8'h7F;
        run_block("ones", 1'b0, 1'b0);
    endtask

    task automatic test_mixed();
        clear_expect();
        blk[0] = 32'h40000000; exp_elem[0] = 8'h40;
        blk[1] = 32'hBF000000; exp_elem[1] = 8'hF0;
        exp_scale = 8'h80;
        run_block("mixed", 1'b0, 1'b0);
    endtask

    task automatic test_rounding();
        clear_expect();
        blk[0] = 32'h3F800000; exp_elem[0] = 8'h40;
        blk[1] = 32'h3C400000;
        blk[2] = 32'h3C000000; exp_elem[2] = 8'h00;
`ifdef MXINT8_QUANT_RNE_EN
        exp_elem[1] = 8'h01;
`else
        exp_elem[1] = 8'h00;
`endif
        exp_scale = 8'h7F;
        run_block("rounding", 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        clear_expect();
        blk[0] = 32'h3FFFFFFF; exp_elem[0] = 8'h7F;
        blk[1] = 32'hBFFFFFFF; exp_elem[1] = 8'h81;
        exp_scale = 8'h7F;
        run_block("clamp", 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        clear_expect();
        run_block("zero", 1'b1, 1'b0);
    endtask

    task automatic test_nan();
        clear_expect();
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F800000;
        blk[5]    = 32'h7FC00000;
        exp_scale = 8'hFF;
        exp_nan   = 1'b1;
        run_block("nan", 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int base;
        base = int'($urandom_range(60, 200));
        for (int i = 0; i < BS; i++) blk[i] = rand_elem(base);
        model();
        send_block(BS, 1'b0);
        wait_result();
        for (int c = 0; c < 5; c++) begin
            bus.i_valid   = 1'b1;
            bus.i_float32 = $urandom;
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_flags cycle %0d: got valid=%b ready=%b expected 1 0",
                         c, bus.o_valid, bus.o_ready);
            end
            check_block("hold");
        end
        bus.i_valid = 1'b0;
        $display("block hold: scale=%h nan=%b held 5 cycles", bus.o_scale, bus.o_nan);
        release_block("hold");
        test_ones();
    endtask

    task automatic test_reset_mid();
        int seen;
        for (int i = 0; i < BS; i++) blk[i] = rand_elem(150);
        send_block(10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_scale !== 8'h00) begin
            errors++;
            $display("FAIL reset_collect: got ready=%b valid=%b scale=%h expected 1 0 00",
                     bus.o_ready, bus.o_valid, bus.o_scale);
        end
        test_ones();
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL extra_block: got %0d valid cycles expected 0", seen);
        end
        // Reset during CONVERT must drop the block entirely.
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F800000;
        send_block(BS, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || bus.o_scale !== 8'h00 || bus.o_mxint8_elements !== '0) begin
            errors++;
            $display("FAIL reset_convert: got %0d valid cycles scale=%h expected 0 and 00",
                     seen, bus.o_scale);
        end
        $display("reset mid-block: valid cycles after reset=%0d", seen);
    endtask

    task automatic test_random();
        int base;
        for (int b = 0; b < 20; b++) begin
            base = int'($urandom_range(60, 200));
            for (int i = 0; i < BS; i++) blk[i] = rand_elem(base);
            run_block($sformatf("rand%0d", b), 1'b1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_mixed();
        test_rounding();
        test_clamp();
        test_zero();
        test_nan();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mxint8_quantize.md
MXINT8_QUANTIZE -- requirements
Module: mxint8_quantize

Interface
REQ-001 The block SHALL have parameter BLOCK_SIZE, default 32, giving the number of elements per MX block.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_valid, input, 1 bit: the input float32 element is valid.
REQ-005 The block SHALL have port i_float32, input, 32 bits: IEEE-754 single-precision element.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts an element this cycle.
REQ-007 The block SHALL have port o_valid, output, 1 bit: the MXINT8 block output is valid.
REQ-008 The block SHALL have port i_ready, input, 1 bit: the downstream consumer accepts the block.
REQ-009 The block SHALL have port o_scale, output, 8 bits: E8M0 shared scale, bias 127.
REQ-010 The block SHALL have port o_mxint8_elements, output, BLOCK_SIZE x 8 bits: two's-complement INT8 elements with an implicit scale of 2^-6.
REQ-011 The block SHALL have port o_nan, output, 1 bit: the block contained an Inf or NaN input.

Function
REQ-012 The FSM SHALL have states COLLECT, CONVERT and HOLD; o_ready SHALL be 1 only in COLLECT, and o_valid SHALL be 1 only in HOLD.
REQ-013 In COLLECT, each i_valid&&o_ready edge SHALL store i_float32 at buffer[cnt], increment cnt, and update max_exp = max(max_exp, i_float32[30:23]).
REQ-014 The edge accepting element BLOCK_SIZE-1 SHALL clear cnt and move the FSM to CONVERT, where one element per cycle is converted in index order 0..BLOCK_SIZE-1.
REQ-015 After element BLOCK_SIZE-1 is converted, the FSM SHALL move to HOLD; o_valid SHALL rise BLOCK_SIZE+1 edges after the last accept edge.
REQ-016 o_scale SHALL equal max_exp, where max_exp is the largest biased float32 exponent in the block.
REQ-017 Each element SHALL be computed as follows: M = {1, mantissa[22:0]}; shift = 17 + (max_exp - exp); magnitude = M >> shift, rounded per REQ-025; the magnitude SHALL be clamped to 127 and negated in two's complement when the sign is 1.
REQ-018 An input with exp==0 (zero or denormal) SHALL produce element 0x00; a shift of 31 or more SHALL yield magnitude 0 before rounding.
REQ-019 If any accepted element has exp==255, o_scale SHALL be 0xFF, all elements SHALL be 0x00, and o_nan SHALL be 1.
REQ-020 An all-zero block SHALL produce o_scale 0x00 and all elements 0x00.
REQ-021 In HOLD, o_scale, o_mxint8_elements and o_nan SHALL remain stable and i_valid SHALL be ignored.
REQ-022 An i_ready&&o_valid edge SHALL return the FSM to COLLECT with max_exp and o_nan cleared, so o_ready is 1 on the next cycle; there is no overlap between blocks.

Reset
REQ-023 Asserting i_rst at any time, including mid-COLLECT or mid-CONVERT, SHALL discard the partial block.
REQ-024 While i_rst is asserted: state = COLLECT, cnt = 0, max_exp = 0, o_ready = 1, o_valid = 0, o_scale = 0, o_nan = 0, all elements = 0.

Configuration
REQ-025 With MXINT8_QUANT_RNE_EN defined, the rounding SHALL be round-to-nearest-even, using guard bit M[shift-1] and sticky bit |M[shift-2:0]; a round-up to 128 SHALL clamp to 127. With the macro undefined, the conversion SHALL truncate toward zero (magnitude = M >> shift).

Verification
REQ-026 32 x 0x3F800000 (1.0) -> o_scale 0x7F, all elements 0x40.
REQ-027 e0 = 0x40000000 (2.0), e1 = 0xBF000000 (-0.5), rest 0 -> o_scale 0x80, e0 = 0x40, e1 = 0xF0.
REQ-028 e0 = 1.0, e1 = 0x3C400000, e2 = 0x3C000000, rest 0, with RNE -> e1 = 0x01, e2 = 0x00; without RNE -> e1 = 0x00, e2 = 0x00.
REQ-029 e5 = 0x7FC00000, all others 1.0 -> o_scale 0xFF, all elements 0x00, o_nan 1.
REQ-030 i_ready held low 5 cycles after o_valid -> outputs stable and o_ready 0; then i_ready 1 -> o_valid 0 and o_ready 1 on the next cycle.
REQ-031 i_rst pulsed after 10 accepts, then 32 x 1.0 -> exactly one block is produced, o_scale 0x7F, all elements 0x40.
